// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_e    : converter FSM encoding (also exported on the debug port)
//   digits_for : number of decimal digits needed for a w-bit unsigned value
//   ctr_w      : width of a counter that must hold the values 0..n
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // ceil(w * log10(2)), evaluated in fixed point (log10(2) ~= 0.30103).
  function automatic int digits_for(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

  // Bits needed to count 0..n, never less than one.
  function automatic int ctr_w(input int n);
    return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
//   digit_i : current 4-bit digit
//   digit_o : corrected digit, ready to be shifted
module bcd_add3_digit (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (iterative shift-add-3), one bit per cycle.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake; bin is taken when both are high
//   bin                 : binary operand (two's complement when SIGNED=1)
//   out_valid/out_ready : result handshake; result held while out_valid & !out_ready
//   bcd                 : packed digits, [3:0] = units
//   neg                 : operand was negative (SIGNED=1 only)
//   ovf                 : magnitude exceeds 10^DIGITS-1, bcd saturated to all 9s
//   blank               : 1 marks a leading-zero digit; bit 0 is never set
//   state_o             : current FSM state, for observation only
//
// Handshake rule: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on the same side's valid, and a producer keeps
// its data stable while valid is high and ready is low.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 9,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank,
  output logic [1:0]            state_o
);

  localparam int DW    = 4 * DIGITS;
  localparam int SH_W  = DW + BIN_W;
  localparam int CTR_W = ctr_w(BIN_W);

  state_e              state_q, state_d;
  logic [SH_W-1:0]     sh_q, sh_d;        // {digits, magnitude}
  logic [CTR_W-1:0]    ctr_q;
  logic                ovf_acc_q;         // sticky: a 1 left the top digit
  logic                sign_q;
  logic [DW-1:0]       bcd_q;
  logic                neg_q, ovf_q;
  logic [DIGITS-1:0]   blank_q;

  logic                accept;
  logic                last_iter;
  logic                carry;
  logic [DW-1:0]       adj;
  logic                sign_in;
  logic [BIN_W-1:0]    mag_in;
  logic                fin_ovf;
  logic [DW-1:0]       fin_bcd;
  logic [DIGITS-1:0]   fin_blank;
  logic                zero_run;

  // ---------------- datapath combinational ----------------
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_i (sh_q[BIN_W + 4*g +: 4]),
      .digit_o (adj[4*g +: 4])
    );
  end

  assign carry     = adj[DW-1];
  assign sh_d      = {adj[DW-2:0], sh_q[BIN_W-1:0], 1'b0};
  assign last_iter = (ctr_q == CTR_W'(BIN_W - 1));

  // The most negative operand negates to itself, which read as unsigned is
  // exactly its magnitude, so no special case is needed.
  assign sign_in = (SIGNED != 0) && bin[BIN_W-1];
  assign mag_in  = sign_in ? -bin : bin;

  // Result formatting uses the value produced by the final iteration so it can
  // be registered on the same edge that enters DONE.
  assign fin_ovf = ovf_acc_q | carry;

  always_comb begin
    fin_bcd   = fin_ovf ? {DIGITS{4'd9}} : sh_d[SH_W-1 -: DW];
    fin_blank = '0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run & (fin_bcd[4*i +: 4] == 4'd0);
      fin_blank[i] = zero_run;
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid)  state_d = ST_SHIFT;
      ST_SHIFT: if (last_iter) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = in_valid ? ST_SHIFT : ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    out_valid = (state_q == ST_DONE);
    accept    = in_valid & in_ready;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q      <= '0;
      ctr_q     <= '0;
      ovf_acc_q <= 1'b0;
      sign_q    <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      blank_q   <= '0;
    end else if (accept) begin
      sh_q      <= {{DW{1'b0}}, mag_in};
      ctr_q     <= '0;
      ovf_acc_q <= 1'b0;
      sign_q    <= sign_in;
    end else if (state_q == ST_SHIFT) begin
      sh_q      <= sh_d;
      ctr_q     <= ctr_q + CTR_W'(1);
      ovf_acc_q <= fin_ovf;
      if (last_iter) begin
        bcd_q   <= fin_bcd;
        neg_q   <= sign_q;
        ovf_q   <= fin_ovf;
        blank_q <= fin_blank;
      end
    end
  end

  assign bcd     = bcd_q;
  assign neg     = neg_q;
  assign ovf     = ovf_q;
  assign blank   = blank_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq in three configurations:
//   u0: BIN_W=9 DIGITS=3 unsigned, u1: BIN_W=8 DIGITS=3 signed, u2: BIN_W=9 DIGITS=2 unsigned.
module tb_bin2bcd_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        iv0, or0, ir0, ov0, ng0, of0;
  logic [8:0]  bn0;
  logic [11:0] bc0;
  logic [2:0]  bl0;
  logic [1:0]  st0;

  logic        iv1, or1, ir1, ov1, ng1, of1;
  logic [7:0]  bn1;
  logic [11:0] bc1;
  logic [2:0]  bl1;
  logic [1:0]  st1;

  logic        iv2, or2, ir2, ov2, ng2, of2;
  logic [8:0]  bn2;
  logic [7:0]  bc2;
  logic [1:0]  bl2;
  logic [1:0]  st2;

  bin2bcd_seq #(.BIN_W(9), .DIGITS(3), .SIGNED(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .bin(bn0),
    .out_valid(ov0), .out_ready(or0), .bcd(bc0), .neg(ng0), .ovf(of0),
    .blank(bl0), .state_o(st0));

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .bin(bn1),
    .out_valid(ov1), .out_ready(or1), .bcd(bc1), .neg(ng1), .ovf(of1),
    .blank(bl1), .state_o(st1));

  bin2bcd_seq #(.BIN_W(9), .DIGITS(2), .SIGNED(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .bin(bn2),
    .out_valid(ov2), .out_ready(or2), .bcd(bc2), .neg(ng2), .ovf(of2),
    .blank(bl2), .state_o(st2));

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q0[$];
  logic [16:0] exp_q1[$];
  logic [16:0] exp_q2[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Result packing used everywhere: {neg, ovf, blank[2:0], bcd[11:0]}, unused bits 0.
  function automatic logic [16:0] obs(input int k);
    case (k)
      0:       return {ng0, of0, bl0, bc0};
      1:       return {ng1, of1, bl1, bc1};
      default: return {ng2, of2, 1'b0, bl2, 4'h0, bc2};
    endcase
  endfunction

  function automatic logic f_ov(input int k);
    case (k)
      0: return ov0;
      1: return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic f_ir(input int k);
    case (k)
      0: return ir0;
      1: return ir1;
      default: return ir2;
    endcase
  endfunction

  function automatic logic [1:0] f_st(input int k);
    case (k)
      0: return st0;
      1: return st1;
      default: return st2;
    endcase
  endfunction

  // ---------------- reference model (decimal arithmetic) ----------------
  function automatic logic [16:0] model(input int k, input int b);
    int w, d, v, mag, lim, sat;
    logic [16:0] r;
    w = (k == 1) ? 8 : 9;
    d = (k == 2) ? 2 : 3;
    v = b & ((1 << w) - 1);
    if (k == 1 && v >= (1 << (w - 1))) v = v - (1 << w);
    mag = (v < 0) ? -v : v;
    lim = (10 ** d) - 1;
    sat = (mag > lim) ? lim : mag;
    r = '0;
    r[16] = (v < 0);
    r[15] = (mag > lim);
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((sat / (10 ** i)) % 10);
    for (int i = 1; i < d; i++) r[12 + i] = ((sat / (10 ** i)) == 0);
    return r;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
      exp_q2.delete();
    end else begin
      if (ov0) begin
        if (exp_q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb0_unexpected: got out_valid=1 expected no pending result");
        end else begin
          check("sb0_result", obs(0), exp_q0[0]);
          if (or0) void'(exp_q0.pop_front());
        end
      end
      if (iv0 && ir0) exp_q0.push_back(model(0, int'(bn0)));

      if (ov1) begin
        if (exp_q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb1_unexpected: got out_valid=1 expected no pending result");
        end else begin
          check("sb1_result", obs(1), exp_q1[0]);
          if (or1) void'(exp_q1.pop_front());
        end
      end
      if (iv1 && ir1) exp_q1.push_back(model(1, int'(bn1)));

      if (ov2) begin
        if (exp_q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb2_unexpected: got out_valid=1 expected no pending result");
        end else begin
          check("sb2_result", obs(2), exp_q2[0]);
          if (or2) void'(exp_q2.pop_front());
        end
      end
      if (iv2 && ir2) exp_q2.push_back(model(2, int'(bn2)));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input int k, input logic v, input int b);
    case (k)
      0: begin iv0 = v; bn0 = b[8:0]; end
      1: begin iv1 = v; bn1 = b[7:0]; end
      default: begin iv2 = v; bn2 = b[8:0]; end
    endcase
  endtask

  // Waits (bounded) for out_valid; returns rising edges counted since the call.
  task automatic wait_out(input int k, output int cnt);
    cnt = 0;
    while (!f_ov(k) && cnt < 60) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  // One conversion from idle with out_ready high; checks latency and result.
  task automatic run(input int k, input int b, input logic [16:0] lit, input string name);
    int cnt, w;
    w = (k == 1) ? 8 : 9;
    check({name, "_model"}, model(k, b), lit);
    @(posedge clk); #1;
    set_in(k, 1'b1, b);
    @(posedge clk); #1;
    set_in(k, 1'b0, 0);
    wait_out(k, cnt);
    check({name, "_latency"}, cnt, w);
    check({name, "_result"}, obs(k), lit);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt, b, guard;
    logic acc;
    rst_n = 1'b0;
    iv0 = 0; iv1 = 0; iv2 = 0;
    or0 = 1; or1 = 1; or2 = 1;
    bn0 = '0; bn1 = '0; bn2 = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("reset_outputs", obs(k), 0);
      check("reset_valid", f_ov(k), 0);
      check("reset_state", f_st(k), 0);
      check("reset_ready", f_ir(k), 1);
    end
    rst_n = 1'b1;

    // Directed conversions with hand-computed results.
    run(0, 0,   {1'b0, 1'b0, 3'b110, 12'h000}, "u0_zero");
    run(0, 511, {1'b0, 1'b0, 3'b000, 12'h511}, "u0_511");
    run(0, 255, {1'b0, 1'b0, 3'b000, 12'h255}, "u0_255");
    run(0, 7,   {1'b0, 1'b0, 3'b110, 12'h007}, "u0_7");
    run(1, 8'h80, {1'b1, 1'b0, 3'b000, 12'h128}, "u1_min");
    run(1, 8'hFF, {1'b1, 1'b0, 3'b110, 12'h001}, "u1_m1");
    run(1, 8'h7F, {1'b0, 1'b0, 3'b000, 12'h127}, "u1_max");
    run(2, 100, {1'b0, 1'b1, 3'b000, 12'h099}, "u2_ovf");
    run(2, 99,  {1'b0, 1'b0, 3'b000, 12'h099}, "u2_99");
    run(2, 5,   {1'b0, 1'b0, 3'b010, 12'h005}, "u2_5");

    // Back-pressure: result held, busy input ignored, then same-edge accept.
    @(posedge clk); #1;
    or0 = 1'b0;
    set_in(0, 1'b1, 123);
    @(posedge clk); #1;
    set_in(0, 1'b1, 200);
    wait_out(0, cnt);
    check("bp_latency", cnt, 9);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_hold_valid", ov0, 1);
      check("bp_hold_ready", ir0, 0);
      check("bp_hold_state", st0, 2);
      check("bp_hold_result", obs(0), {1'b0, 1'b0, 3'b000, 12'h123});
    end
    bn0 = 9'd42;
    or0 = 1'b1;
    @(posedge clk); #1;
    set_in(0, 1'b0, 0);
    check("bp_reaccept_valid", ov0, 0);
    check("bp_reaccept_state", st0, 1);
    wait_out(0, cnt);
    check("bp2_latency", cnt, 9);
    check("bp2_result", obs(0), {1'b0, 1'b0, 3'b100, 12'h042});
    @(posedge clk); #1;

    // Reset during the fourth iteration of bin=300.
    set_in(0, 1'b1, 300);
    @(posedge clk); #1;
    set_in(0, 1'b0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_state_before", st0, 1);
    rst_n = 1'b0;
    #3;
    check("rst_mid_state_async", st0, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_mid_ready", ir0, 1);
    repeat (15) begin
      @(posedge clk); #1;
      check("rst_mid_no_valid", ov0, 0);
    end
    check("rst_mid_state_after", st0, 0);

    // Sweep every 9-bit operand with random out_ready (scoreboard checks results).
    b = 0;
    guard = 0;
    set_in(0, 1'b1, 0);
    while (b < 512 && guard < 20000) begin
      @(negedge clk);
      acc = ir0;
      @(posedge clk); #1;
      guard++;
      or0 = 1'($urandom_range(0, 1));
      if (acc) begin
        b++;
        set_in(0, b < 512, b);
      end
    end
    check("sweep_accepted", b, 512);
    set_in(0, 1'b0, 0);
    or0 = 1'b1;
    guard = 0;
    while (exp_q0.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_q0", exp_q0.size(), 0);
    check("drain_q1", exp_q1.size(), 0);
    check("drain_q2", exp_q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
